fft_host_ctrl: RTL and testbench

- Host-side initiator for fft_accel: accepts a job command (signal number, FFT/IFFT), fetches the input signal lines from host memory and streams them into the accelerator's input FIFO (loadInFifo/mcDataIn).
- Starts the transform, waits for done, then pulls result lines out of the accelerator's output FIFO (loadFifoFromRam → mcDataOut/mcDataOutValid) and writes them back to host memory.
- Sits between the memory-controller port and fft_accel.

---
 rtl/fft_host_ctrl_if.sv | 58 +++++
 rtl/fft_host_ctrl.sv | 148 ++++++++++++++
 tb/tb_fft_host_ctrl.sv | 466 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fft_host_ctrl_if.sv
// Host-controller bus bundle: job command, host-memory port and fft_accel port.
// master = controller side, slave = host/memory/accel side.
interface fft_host_ctrl_if #(
  parameter int LINE_W = 7
);
  logic              cmdValid;
  logic              cmdIfft;
  logic [17:0]       cmdSigNum;
  logic              cmdReady;
  logic              jobDone;
  logic              jobErr;

  logic              rdReq;
  logic [LINE_W-1:0] rdLine;
  logic              rdValid;
  logic [511:0]      rdData;
  logic              wrReq;
  logic [LINE_W-1:0] wrLine;
  logic [511:0]      wrData;
  logic              wrReady;
  logic [17:0]       memSigNum;

  logic              startF;
  logic              startI;
  logic              loadInFifo;
  logic [511:0]      mcDataIn;
  logic [17:0]       sigNum;
  logic              done;
  logic              calculating;
  logic              outFifoReady;
  logic              loadFifoFromRam;
  logic [511:0]      mcDataOut;
  logic              mcDataOutValid;

  modport master (
    input  cmdValid, cmdIfft, cmdSigNum,
    input  rdValid, rdData, wrReady,
    input  done, calculating, outFifoReady,
    input  mcDataOut, mcDataOutValid,
    output cmdReady, jobDone, jobErr,
    output rdReq, rdLine, wrReq, wrLine, wrData,
    output memSigNum, startF, startI,
    output loadInFifo, mcDataIn, sigNum,
    output loadFifoFromRam
  );

  modport slave (
    output cmdValid, cmdIfft, cmdSigNum,
    output rdValid, rdData, wrReady,
    output done, calculating, outFifoReady,
    output mcDataOut, mcDataOutValid,
    input  cmdReady, jobDone, jobErr,
    input  rdReq, rdLine, wrReq, wrLine, wrData,
    input  memSigNum, startF, startI,
    input  loadInFifo, mcDataIn, sigNum,
    input  loadFifoFromRam
  );
endinterface

// File: rtl/fft_host_ctrl.sv
// Host-side job sequencer for fft_accel: streams a signal in,
// runs the transform and drains the result lines back to host memory.
module fft_host_ctrl #(
  parameter int NUM_LINES = 128,
  parameter int LINE_W    = 7,
  parameter int TIMEOUT   = 4096
) (
  input logic             clk,
  input logic             rst,
  fft_host_ctrl_if.master bus
);

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_PUSH, S_START, S_WAIT,
    S_REQ, S_RECV, S_WRITE, S_FIN
  } state_t;

  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam logic [LINE_W-1:0] LAST = LINE_W'(NUM_LINES - 1);
  localparam logic [WD_W-1:0] WD_HIT = WD_W'(TIMEOUT - 1);

  state_t state, state_nx;

  logic [LINE_W-1:0] cnt;
  logic [WD_W-1:0]   wd;
  logic              ifft;
  logic [17:0]       sig;
  logic              err;
  logic [511:0]      din;
  logic [511:0]      wdat;
  logic [LINE_W-1:0] wline;

  logic last;
  logic wd_to;
  logic accept;
  logic spur;
  logic tmo;
  logic unused;

  assign last   = (cnt == LAST);
  assign wd_to  = (wd == WD_HIT);
  assign accept = (state == S_IDLE) && bus.cmdValid;
  assign spur   = bus.mcDataOutValid && (state != S_RECV);
  // wd holds cycles since the last start/pull pulse
  assign tmo = wd_to &&
    (((state == S_WAIT) && !bus.done) ||
     ((state == S_RECV) && !bus.mcDataOutValid));
  assign unused = bus.calculating;

  assign bus.rdLine    = cnt;
  assign bus.wrLine    = wline;
  assign bus.wrData    = wdat;
  assign bus.mcDataIn  = din;
  assign bus.sigNum    = sig;
  assign bus.memSigNum = sig;
  assign bus.jobErr    = err;

  always_ff @(posedge clk) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  if (bus.cmdValid) state_nx = S_FETCH;
      S_FETCH: if (bus.rdValid) state_nx = S_PUSH;
      S_PUSH:  state_nx = last ? S_START : S_FETCH;
      S_START: state_nx = S_WAIT;
      S_WAIT: begin
        if (bus.done)   state_nx = S_REQ;
        else if (wd_to) state_nx = S_FIN;
      end
      S_REQ:   if (bus.outFifoReady) state_nx = S_RECV;
      S_RECV: begin
        if (bus.mcDataOutValid) state_nx = S_WRITE;
        else if (wd_to)         state_nx = S_FIN;
      end
      S_WRITE: if (bus.wrReady) state_nx = last ? S_FIN : S_REQ;
      S_FIN:   state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    bus.cmdReady        = 1'b0;
    bus.rdReq           = 1'b0;
    bus.loadInFifo      = 1'b0;
    bus.startF          = 1'b0;
    bus.startI          = 1'b0;
    bus.loadFifoFromRam = 1'b0;
    bus.wrReq           = 1'b0;
    bus.jobDone         = 1'b0;
    unique case (state)
      S_IDLE:  bus.cmdReady = 1'b1;
      S_FETCH: bus.rdReq = 1'b1;
      S_PUSH:  bus.loadInFifo = 1'b1;
      S_START: begin
        bus.startI = ifft;
        bus.startF = !ifft;
      end
      S_REQ:   bus.loadFifoFromRam = bus.outFifoReady;
      S_WRITE: bus.wrReq = 1'b1;
      S_FIN:   bus.jobDone = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt   <= '0;
      wd    <= '0;
      ifft  <= 1'b0;
      sig   <= '0;
      err   <= 1'b0;
      din   <= '0;
      wdat  <= '0;
      wline <= '0;
    end else begin
      err <= (err && !accept) || spur || tmo;
      unique case (state)
        S_IDLE: begin
          if (bus.cmdValid) begin
            ifft <= bus.cmdIfft;
            sig  <= bus.cmdSigNum;
            cnt  <= '0;
          end
        end
        S_FETCH: if (bus.rdValid) din <= bus.rdData;
        S_PUSH:  cnt <= last ? '0 : cnt + 1'b1;
        S_START: wd <= WD_W'(1);
        S_WAIT:  wd <= wd + 1'b1;
        S_REQ:   if (bus.outFifoReady) wd <= WD_W'(1);
        S_RECV: begin
          if (bus.mcDataOutValid) begin
            wdat  <= bus.mcDataOut;
            wline <= cnt;
          end else begin
            wd <= wd + 1'b1;
          end
        end
        S_WRITE: if (bus.wrReady && !last) cnt <= cnt + 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fft_host_ctrl.sv
// Bench for fft_host_ctrl: behavioural host memory and accelerator,
// randomized jobs checked against the expected line streams.
module tb_fft_host_ctrl;
  localparam int NL = 128;
  localparam int LW = 7;
  localparam int TO = 4096;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fft_host_ctrl_if #(.LINE_W(LW)) bus ();

  fft_host_ctrl #(.NUM_LINES(NL), .LINE_W(LW), .TIMEOUT(TO)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0]  key = 8'h00;
  int          rd_lat = 1;
  int          wr_max = 0;
  int          done_dly = 20;
  bit          bp = 1'b0;
  bit          spur_req = 1'b0;
  logic [17:0] job_sig = '0;

  logic [511:0] load_q[$];
  int           wl_q[$];
  logic [511:0] wd_q[$];
  int n_sf, n_si, n_both, n_lfr, n_done;
  int start_cyc, done_cyc, loads_at_start;
  int wr_unstable, sig_bad;
  logic err_at_done;

  function automatic logic [511:0] pat(int i);
    logic [7:0] b;
    b = 8'(i) ^ key;
    return {64{b}};
  endfunction

  function automatic int load_bad();
    int bad = 0;
    if (load_q.size() != NL) bad++;
    for (int i = 0; i < NL; i++)
      if (i >= load_q.size() || load_q[i] !== pat(i)) bad++;
    return bad;
  endfunction

  function automatic int write_bad();
    int bad = 0;
    if (wl_q.size() != NL) bad++;
    for (int i = 0; i < NL; i++)
      if (i >= wl_q.size() || wl_q[i] != i || wd_q[i] !== ~pat(i)) bad++;
    return bad;
  endfunction

  task automatic clear_env();
    load_q.delete();
    wl_q.delete();
    wd_q.delete();
    n_sf = 0; n_si = 0; n_both = 0; n_lfr = 0; n_done = 0;
    start_cyc = 0; done_cyc = 0; loads_at_start = -1;
    wr_unstable = 0; sig_bad = 0; err_at_done = 1'bx;
  endtask

  // host memory + accelerator model
  initial begin
    int rd_wait, wr_hold, ofr_low, done_at;
    bit wr_pend;
    logic [LW-1:0] wl0;
    logic [511:0] wd0;
    int resp_at[$];
    int resp_idx[$];
    rd_wait = 0; wr_hold = 0; ofr_low = 0; done_at = -1; wr_pend = 0;
    wl0 = '0; wd0 = '0;
    bus.rdValid = 0; bus.rdData = '0; bus.wrReady = 0;
    bus.done = 0; bus.calculating = 0; bus.outFifoReady = 1;
    bus.mcDataOut = '0; bus.mcDataOutValid = 0;
    forever begin
      @(negedge clk);
      bus.done = (done_at >= 0) && (cyc == done_at);
      bus.calculating = (done_at >= 0) && (cyc < done_at);
      bus.outFifoReady = 1'b1;
      if (ofr_low > 0) begin
        bus.outFifoReady = 1'b0;
        ofr_low--;
      end
      bus.rdValid = 1'b0;
      if (bus.rdReq === 1'b1) begin
        if (rd_wait >= rd_lat) begin
          bus.rdValid = 1'b1;
          bus.rdData = pat(int'(bus.rdLine));
          rd_wait = 0;
        end else rd_wait++;
      end
      bus.wrReady = 1'b0;
      if (bus.wrReq === 1'b1) begin
        if (!wr_pend) begin
          wr_pend = 1;
          wl0 = bus.wrLine;
          wd0 = bus.wrData;
          wr_hold = (bp && bus.wrLine == 7'd3) ? 5 : int'($urandom_range(wr_max, 0));
        end else if (bus.wrLine !== wl0 || bus.wrData !== wd0) wr_unstable++;
        if (wr_hold > 0) wr_hold--;
        else begin
          bus.wrReady = 1'b1;
          wr_pend = 0;
          wl_q.push_back(int'(bus.wrLine));
          wd_q.push_back(bus.wrData);
          if (bp && bus.wrLine == 7'd9) ofr_low = 4;
        end
      end
      bus.mcDataOutValid = 1'b0;
      if (resp_at.size() > 0 && resp_at[0] == cyc) begin
        bus.mcDataOutValid = 1'b1;
        bus.mcDataOut = ~pat(resp_idx[0]);
        void'(resp_at.pop_front());
        void'(resp_idx.pop_front());
      end
      if (spur_req && bus.rdReq === 1'b1 && bus.rdLine == 7'd5) begin
        bus.mcDataOutValid = 1'b1;
        bus.mcDataOut = '1;
        spur_req = 0;
      end
      #1;
      if (bus.loadInFifo === 1'b1) load_q.push_back(bus.mcDataIn);
      if (bus.startF === 1'b1 && bus.startI === 1'b1) n_both++;
      if (bus.startF === 1'b1) n_sf++;
      if (bus.startI === 1'b1) n_si++;
      if (bus.startF === 1'b1 || bus.startI === 1'b1) begin
        start_cyc = cyc;
        loads_at_start = load_q.size();
        done_at = (done_dly >= 0) ? cyc + done_dly : -1;
      end
      if (bus.jobDone === 1'b1) begin
        n_done++;
        done_cyc = cyc;
        err_at_done = bus.jobErr;
      end
      if (bus.cmdReady === 1'b0 &&
          (bus.sigNum !== job_sig || bus.memSigNum !== job_sig)) sig_bad++;
      if (bus.loadFifoFromRam === 1'b1) begin
        resp_at.push_back(cyc + 2);
        resp_idx.push_back(n_lfr);
        n_lfr++;
      end
      if (rst === 1'b0) begin
        rd_wait = 0; wr_pend = 0; wr_hold = 0; ofr_low = 0; done_at = -1;
        resp_at.delete();
        resp_idx.delete();
      end
    end
  end

  task automatic start_job(input bit ifft, input logic [17:0] sig);
    @(negedge clk);
    job_sig = sig;
    bus.cmdIfft = ifft;
    bus.cmdSigNum = sig;
    bus.cmdValid = 1'b1;
    @(negedge clk);
    bus.cmdValid = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    int n0;
    n0 = n_done;
    ok = 0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      #2;
      if (n_done > n0) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    logic [8:0] ctl;
    repeat (3) @(negedge clk);
    ctl = {bus.cmdReady, bus.jobDone, bus.jobErr, bus.rdReq, bus.wrReq,
           bus.startF, bus.startI, bus.loadInFifo, bus.loadFifoFromRam};
    checks++;
    if (ctl !== 9'h100) begin
      errors++;
      $display("FAIL reset_ctl: got %b want %b", ctl, 9'h100);
    end
    checks++;
    if (bus.rdLine !== '0 || bus.wrLine !== '0) begin
      errors++;
      $display("FAIL reset_lines: rd=%0h wr=%0h want 0", bus.rdLine, bus.wrLine);
    end
    checks++;
    if (bus.wrData !== '0 || bus.mcDataIn !== '0) begin
      errors++;
      $display("FAIL reset_data: nonzero wrData/mcDataIn, want 0");
    end
    checks++;
    if (bus.sigNum !== '0 || bus.memSigNum !== '0) begin
      errors++;
      $display("FAIL reset_sig: sig=%0h mem=%0h want 0", bus.sigNum, bus.memSigNum);
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_fft_job();
    bit ok;
    int b;
    clear_env();
    key = 8'h00; rd_lat = 1; wr_max = 0; done_dly = 20; bp = 0;
    start_job(1'b0, 18'h00005);
    wait_done(3000, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL fft_done: no jobDone within budget"); end
    checks++;
    if (loads_at_start != NL) begin
      errors++;
      $display("FAIL fft_loads_before_start: got %0d want %0d", loads_at_start, NL);
    end
    b = load_bad();
    checks++;
    if (b != 0) begin errors++; $display("FAIL fft_load_data: bad=%0d want 0", b); end
    checks++;
    if (n_sf != 1 || n_si != 0 || n_both != 0) begin
      errors++;
      $display("FAIL fft_start: startF=%0d startI=%0d want 1/0", n_sf, n_si);
    end
    checks++;
    if (sig_bad != 0) begin errors++; $display("FAIL fft_signum: bad=%0d want 0", sig_bad); end
    b = write_bad();
    checks++;
    if (b != 0 || err_at_done !== 1'b0) begin
      errors++;
      $display("FAIL fft_writes: bad=%0d err=%b want 0/0", b, err_at_done);
    end
  endtask

  task automatic test_ifft_job();
    bit ok;
    int b;
    clear_env();
    key = 8'($urandom); rd_lat = 1; wr_max = 0; done_dly = 20; bp = 0;
    start_job(1'b1, 18'($urandom));
    wait_done(3000, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL ifft_done: no jobDone within budget"); end
    checks++;
    if (n_si != 1 || n_sf != 0 || n_both != 0) begin
      errors++;
      $display("FAIL ifft_start: startI=%0d startF=%0d want 1/0", n_si, n_sf);
    end
    b = write_bad();
    checks++;
    if (b != 0) begin errors++; $display("FAIL ifft_writes: bad=%0d want 0", b); end
    checks++;
    if (n_done != 1 || err_at_done !== 1'b0) begin
      errors++;
      $display("FAIL ifft_jobdone: pulses=%0d err=%b want 1/0", n_done, err_at_done);
    end
    @(negedge clk);
    checks++;
    if (bus.cmdReady !== 1'b1) begin
      errors++;
      $display("FAIL ifft_ready: got %b want 1", bus.cmdReady);
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    int b;
    clear_env();
    key = 8'($urandom); rd_lat = int'($urandom_range(3, 0));
    wr_max = 2; done_dly = 20; bp = 1;
    start_job(1'($urandom), 18'($urandom));
    wait_done(5000, ok);
    bp = 0; wr_max = 0;
    checks++;
    if (!ok) begin errors++; $display("FAIL bp_done: no jobDone within budget"); end
    checks++;
    if (wr_unstable != 0) begin
      errors++;
      $display("FAIL bp_stable: unstable=%0d want 0", wr_unstable);
    end
    checks++;
    if (n_lfr != NL) begin errors++; $display("FAIL bp_pulls: got %0d want %0d", n_lfr, NL); end
    b = write_bad();
    checks++;
    if (b != 0 || err_at_done !== 1'b0) begin
      errors++;
      $display("FAIL bp_writes: bad=%0d err=%b want 0/0", b, err_at_done);
    end
  endtask

  task automatic test_timeout();
    bit ok;
    clear_env();
    key = 8'($urandom); rd_lat = 0; done_dly = -1;
    start_job(1'b0, 18'($urandom));
    wait_done(TO + 1000, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL to_done: no jobDone within budget"); end
    checks++;
    if (err_at_done !== 1'b1) begin
      errors++;
      $display("FAIL to_err: got %b want 1", err_at_done);
    end
    checks++;
    if (done_cyc - start_cyc != TO) begin
      errors++;
      $display("FAIL to_latency: got %0d want %0d", done_cyc - start_cyc, TO);
    end
    checks++;
    if (n_lfr != 0) begin errors++; $display("FAIL to_pulls: got %0d want 0", n_lfr); end
    @(negedge clk);
    checks++;
    if (bus.cmdReady !== 1'b1) begin
      errors++;
      $display("FAIL to_ready: got %b want 1", bus.cmdReady);
    end
    done_dly = 20;
    start_job(1'b1, 18'($urandom));
    checks++;
    if (bus.jobErr !== 1'b0) begin
      errors++;
      $display("FAIL to_err_clear: got %b want 0", bus.jobErr);
    end
    wait_done(3000, ok);
    checks++;
    if (!ok || err_at_done !== 1'b0) begin
      errors++;
      $display("FAIL to_next_job: ok=%0d err=%b want 1/0", ok, err_at_done);
    end
  endtask

  task automatic test_spurious();
    bit ok;
    bit seen;
    int b;
    logic [17:0] s;
    clear_env();
    key = 8'($urandom); rd_lat = 1; done_dly = int'($urandom_range(60, 30));
    s = 18'($urandom);
    spur_req = 1;
    start_job(1'b0, s);
    seen = 0;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      #2;
      if (n_sf + n_si > 0) begin
        seen = 1;
        break;
      end
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL sp_start: no start pulse within budget"); end
    @(negedge clk);
    bus.cmdSigNum = ~s;
    bus.cmdIfft = 1'b1;
    bus.cmdValid = 1'b1;
    repeat (3) @(negedge clk);
    bus.cmdValid = 1'b0;
    wait_done(3000, ok);
    checks++;
    if (!ok || err_at_done !== 1'b1) begin
      errors++;
      $display("FAIL sp_err: ok=%0d err=%b want 1/1", ok, err_at_done);
    end
    b = load_bad();
    checks++;
    if (b != 0) begin errors++; $display("FAIL sp_loads: bad=%0d want 0", b); end
    b = write_bad();
    checks++;
    if (b != 0) begin errors++; $display("FAIL sp_writes: bad=%0d want 0", b); end
    checks++;
    if (sig_bad != 0 || n_si != 0 || n_sf != 1) begin
      errors++;
      $display("FAIL sp_wait_cmd: sigbad=%0d startI=%0d startF=%0d want 0/0/1",
               sig_bad, n_si, n_sf);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (bus.cmdReady !== 1'b1 || bus.rdReq !== 1'b0 || n_done != 1) begin
      errors++;
      $display("FAIL sp_idle: ready=%b rdReq=%b done=%0d want 1/0/1",
               bus.cmdReady, bus.rdReq, n_done);
    end
  endtask

  task automatic test_reset_mid_job();
    bit ok;
    bit seen;
    int b;
    logic [8:0] ctl;
    clear_env();
    key = 8'($urandom); rd_lat = 1; done_dly = 20;
    start_job(1'b0, 18'($urandom));
    seen = 0;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      #2;
      if (bus.loadInFifo === 1'b1 && bus.mcDataIn === pat(40)) begin
        seen = 1;
        break;
      end
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL rm_push40: line 40 push not seen"); end
    rst = 1'b0;
    @(negedge clk);
    ctl = {bus.cmdReady, bus.jobDone, bus.jobErr, bus.rdReq, bus.wrReq,
           bus.startF, bus.startI, bus.loadInFifo, bus.loadFifoFromRam};
    checks++;
    if (ctl !== 9'h100) begin
      errors++;
      $display("FAIL rm_ctl: got %b want %b", ctl, 9'h100);
    end
    checks++;
    if (bus.rdLine !== '0 || bus.mcDataIn !== '0 || bus.sigNum !== '0 || bus.memSigNum !== '0) begin
      errors++;
      $display("FAIL rm_regs: rdLine=%0d sig=%0h want 0", bus.rdLine, bus.sigNum);
    end
    @(negedge clk);
    rst = 1'b1;
    clear_env();
    repeat (5) @(negedge clk);
    checks++;
    if (load_q.size() != 0 || n_sf + n_si != 0 || n_lfr != 0) begin
      errors++;
      $display("FAIL rm_quiet: loads=%0d starts=%0d pulls=%0d want 0", load_q.size(),
               n_sf + n_si, n_lfr);
    end
    start_job(1'b1, 18'($urandom));
    wait_done(3000, ok);
    b = load_bad() + write_bad();
    checks++;
    if (!ok || b != 0) begin
      errors++;
      $display("FAIL rm_restart: ok=%0d bad=%0d want 1/0", ok, b);
    end
  endtask

  initial begin
    bus.cmdValid = 1'b0;
    bus.cmdIfft = 1'b0;
    bus.cmdSigNum = '0;
    clear_env();
    test_reset();
    test_fft_job();
    test_ifft_job();
    test_backpressure();
    test_timeout();
    test_spurious();
    test_reset_mid_job();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
